// File: rtl/prog_timer.sv
// Runtime-programmable interval timer: periodic or one-shot expiry with
// prescaler, hold, stop/restart and a registered config-error pulse.
module prog_timer #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned PRESCALE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             oneshot,
  input  logic [WIDTH-1:0] period,
  output logic             tick,
  output logic             busy,
  output logic             expired,
  output logic [WIDTH-1:0] count,
  output logic             cfg_err
);

  localparam int unsigned     PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_n;
  logic [PW-1:0]    pre, pre_n;
  logic [WIDTH-1:0] count_n;
  logic [WIDTH-1:0] plat, plat_n;
  logic             mode, mode_n;
  logic             start_ok, start_bad, advance;

  assign start_ok  = start && !stop && (period != '0);
  assign start_bad = start && !stop && (period == '0);

  // A rejected start does not disturb the run: counting and tick continue.
  assign advance = (state == RUN) && !hold && !stop && !start_ok;
  assign tick    = advance && (pre == PRE_MAX) && (count == plat - WIDTH'(1));

  assign busy    = (state == RUN);
  assign expired = (state == DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      pre     <= '0;
      count   <= '0;
      plat    <= '0;
      mode    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state   <= state_n;
      pre     <= pre_n;
      count   <= count_n;
      plat    <= plat_n;
      mode    <= mode_n;
      cfg_err <= start_bad;
    end
  end

  always_comb begin
    state_n = state;
    pre_n   = pre;
    count_n = count;
    plat_n  = plat;
    mode_n  = mode;
    if (stop) begin
      state_n = IDLE;
      pre_n   = '0;
      count_n = '0;
    end else if (start_ok) begin
      state_n = RUN;
      pre_n   = '0;
      count_n = '0;
      plat_n  = period;
      mode_n  = oneshot;
    end else if (advance) begin
      if (pre == PRE_MAX) begin
        pre_n = '0;
        if (tick) begin
          count_n = '0;
          if (mode) state_n = DONE;
        end else begin
          count_n = count + WIDTH'(1);
        end
      end else begin
        pre_n = pre + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_prog_timer.sv
// Directed bench for prog_timer: expected tick edges are queued when a start
// is driven and consumed by a per-cycle tick monitor.
module tb_prog_timer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start_a = 1'b0, stop_a = 1'b0, hold_a = 1'b0, oneshot_a = 1'b0;
  logic [7:0] period_a = '0;
  logic       tick_a, busy_a, expired_a, cfg_err_a;
  logic [7:0] count_a;
  logic       start_b = 1'b0, stop_b = 1'b0, hold_b = 1'b0, oneshot_b = 1'b0;
  logic [7:0] period_b = '0;
  logic       tick_b, busy_b, expired_b, cfg_err_b;
  logic [7:0] count_b;

  int checks = 0;
  int errors = 0;
  int ecount = 0;
  int t0, t1;
  int qa[$];
  int qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  prog_timer #(.WIDTH(8), .PRESCALE(1)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .stop(stop_a), .hold(hold_a),
    .oneshot(oneshot_a), .period(period_a), .tick(tick_a), .busy(busy_a),
    .expired(expired_a), .count(count_a), .cfg_err(cfg_err_a)
  );

  prog_timer #(.WIDTH(8), .PRESCALE(4)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .stop(stop_b), .hold(hold_b),
    .oneshot(oneshot_b), .period(period_b), .tick(tick_b), .busy(busy_b),
    .expired(expired_b), .count(count_b), .cfg_err(cfg_err_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step_clk(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Tick seen before edge ecount+1 belongs to cycle ecount+1.
  always @(negedge clk) begin
    if (!reset) begin
      if (qa.size() > 0 && qa[0] == ecount + 1) begin
        void'(qa.pop_front());
        check("tick_a_expected", tick_a, 1);
      end else begin
        check("tick_a_quiet", tick_a, 0);
      end
      if (qb.size() > 0 && qb[0] == ecount + 1) begin
        void'(qb.pop_front());
        check("tick_b_expected", tick_b, 1);
      end else begin
        check("tick_b_quiet", tick_b, 0);
      end
    end
  end

  initial begin
    step_clk(2);
    reset = 1'b0;
    check("rst_busy", busy_a, 0);
    check("rst_expired", expired_a, 0);
    check("rst_count", count_a, 0);
    check("rst_cfg_err", cfg_err_a, 0);
    check("rst_tick", tick_a, 0);
    check("rst_busy_b", busy_b, 0);

    // Periodic, period 5
    period_a = 8'd5; oneshot_a = 1'b0; start_a = 1'b1;
    t0 = ecount + 1;
    qa.push_back(t0 + 5); qa.push_back(t0 + 10); qa.push_back(t0 + 15);
    step_clk(1);
    start_a = 1'b0;
    check("per_count0", count_a, 0);
    check("per_busy0", busy_a, 1);
    for (int k = 1; k <= 5; k++) begin
      step_clk(1);
      check("per_count", count_a, k % 5);
      check("per_busy", busy_a, 1);
    end
    step_clk(10);
    stop_a = 1'b1; step_clk(1); stop_a = 1'b0;
    check("per_stop_busy", busy_a, 0);

    // One-shot, period 3
    period_a = 8'd3; oneshot_a = 1'b1; start_a = 1'b1;
    t0 = ecount + 1;
    qa.push_back(t0 + 3);
    step_clk(1);
    start_a = 1'b0;
    step_clk(3);
    check("os_expired", expired_a, 1);
    check("os_busy", busy_a, 0);
    check("os_count", count_a, 0);
    step_clk(20);
    check("os_expired_hold", expired_a, 1);
    check("os_count_hold", count_a, 0);
    stop_a = 1'b1; step_clk(1); stop_a = 1'b0;
    check("os_stop_expired", expired_a, 0);

    // Hold for 3 cycles at count 2, period 4
    period_a = 8'd4; oneshot_a = 1'b0; start_a = 1'b1;
    t0 = ecount + 1;
    qa.push_back(t0 + 7); qa.push_back(t0 + 11); qa.push_back(t0 + 15);
    step_clk(1);
    start_a = 1'b0;
    step_clk(2);
    check("hold_pre_count", count_a, 2);
    hold_a = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step_clk(1);
      check("hold_count", count_a, 2);
    end
    hold_a = 1'b0;
    step_clk(10);
    stop_a = 1'b1; step_clk(1); stop_a = 1'b0;

    // Zero period while idle
    period_a = 8'd0; start_a = 1'b1; step_clk(1); start_a = 1'b0;
    check("cfg_idle_err", cfg_err_a, 1);
    check("cfg_idle_busy", busy_a, 0);
    step_clk(1);
    check("cfg_idle_err_clr", cfg_err_a, 0);

    // Zero period while running with period 6
    period_a = 8'd6; start_a = 1'b1;
    t0 = ecount + 1;
    qa.push_back(t0 + 6); qa.push_back(t0 + 12);
    step_clk(1);
    start_a = 1'b0;
    step_clk(1);
    period_a = 8'd0; start_a = 1'b1;
    step_clk(1);
    start_a = 1'b0; period_a = 8'd6;
    check("cfg_run_err", cfg_err_a, 1);
    check("cfg_run_busy", busy_a, 1);
    check("cfg_run_count", count_a, 2);
    step_clk(1);
    check("cfg_run_err_clr", cfg_err_a, 0);
    step_clk(9);
    stop_a = 1'b1; step_clk(1); stop_a = 1'b0;

    // Prescale 4, period 3, restart with period 2 on a terminal cycle
    period_b = 8'd3; oneshot_b = 1'b0; start_b = 1'b1;
    t0 = ecount + 1;
    qb.push_back(t0 + 12); qb.push_back(t0 + 24);
    step_clk(1);
    start_b = 1'b0;
    step_clk(35);
    period_b = 8'd2; start_b = 1'b1;
    #1 check("pre_restart_tick", tick_b, 0);
    t1 = ecount + 1;
    qb.push_back(t1 + 8);
    step_clk(1);
    start_b = 1'b0;
    check("pre_restart_count", count_b, 0);
    step_clk(8);
    check("pre_busy", busy_b, 1);
    stop_b = 1'b1; step_clk(1); stop_b = 1'b0;

    // start and stop together while running
    period_a = 8'd5; start_a = 1'b1; step_clk(1); start_a = 1'b0;
    step_clk(2);
    start_a = 1'b1; stop_a = 1'b1;
    step_clk(1);
    start_a = 1'b0; stop_a = 1'b0;
    check("ss_busy", busy_a, 0);
    check("ss_count", count_a, 0);

    // stop on the terminal cycle
    period_a = 8'd3; start_a = 1'b1; step_clk(1); start_a = 1'b0;
    step_clk(2);
    stop_a = 1'b1;
    #1 check("stop_term_tick", tick_a, 0);
    step_clk(1);
    stop_a = 1'b0;
    check("stop_term_busy", busy_a, 0);

    // reset mid-run
    period_a = 8'd5; start_a = 1'b1; step_clk(1); start_a = 1'b0;
    step_clk(2);
    reset = 1'b1; step_clk(1);
    check("mr_busy", busy_a, 0);
    check("mr_count", count_a, 0);
    check("mr_expired", expired_a, 0);
    check("mr_cfg_err", cfg_err_a, 0);
    check("mr_tick", tick_a, 0);
    reset = 1'b0;

    // maximum period
    period_a = 8'd255; oneshot_a = 1'b0; start_a = 1'b1;
    t0 = ecount + 1;
    qa.push_back(t0 + 255);
    step_clk(1);
    start_a = 1'b0;
    step_clk(254);
    check("max_count", count_a, 254);
    check("max_tick", tick_a, 1);
    step_clk(1);
    check("max_wrap", count_a, 0);
    check("max_busy", busy_a, 1);
    stop_a = 1'b1; step_clk(1); stop_a = 1'b0;

    step_clk(2);
    check("qa_drained", qa.size(), 0);
    check("qb_drained", qb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
